phase_generator: RTL
====================

# phase_generator

Programmable periodic pulse source on the phase-measurement path: it produces a `Phase_out` pulse train whose rising-edge-to-rising-edge spacing is a loaded cycle count. It is the transmit end of the phase/period detector. It drives that detector's `Phase_in` for loopback self-test and serves as the board's reference phase output. Period updates are shadowed and applied only at a period boundary, so the output never glitches.

## Interface
- `HIGH_CYCLES`, default 200: high time of each pulse in clocks. Must exceed the detector's 100-cycle input filter.
- `MIN_PERIOD`, default 400: smallest accepted period. Must be at least 2·`HIGH_CYCLES`.
- `MAX_PERIOD`, default 400000000: largest accepted period. Equals the detector timeout.
- `DEFAULT_PERIOD`, default 20000000: active period after reset.
- `clk` input, 1: single clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `enable` input, 1: run the generator. When low, the output is forced low.
- `period_in` input, 32: requested period in clocks.
- `period_load` input, 1: single-cycle strobe that captures `period_in`.
- `Phase_out` output, 1: generated pulse train.
- `Phase_start` output, 1: one-cycle strobe coincident with each rising edge of `Phase_out`.
- `active` output, 1: high while the FSM is out of IDLE.
- `load_err` output, 1: sticky flag set by a rejected load.
- `period_cur` output, 32: period currently being generated.

## Operation
- FSM states:
  - IDLE:
    - `Phase_out`=0; counter `cnt` held at 0.
    - Moves to HIGH on the first cycle `enable`=1.
  - HIGH:
    - `Phase_out`=1; `cnt` increments.
    - At `cnt`==`HIGH_CYCLES`-1 → LOW.
  - LOW:
    - `Phase_out`=0; `cnt` increments.
    - At `cnt`==`period_cur`-1 (boundary) → HIGH with `cnt`=0 and `Phase_start`=1.
  - `enable`=0 in any state → IDLE next cycle, `cnt`=0.
- Load validation:
  - `period_load` with `MIN_PERIOD` ≤ `period_in` ≤ `MAX_PERIOD` writes the pending register, sets the pending flag and clears `load_err`.
  - A load outside that range sets `load_err`; pending and active registers are unchanged.
- Shadow update: at each boundary, and on IDLE→HIGH, `period_cur` takes the pending value if the pending flag is set, then the flag clears.
- Simultaneous events:
  - Valid load on a boundary cycle: the loaded value is used for the period starting at that boundary.
  - Multiple loads between boundaries: the last valid load wins.
  - Load while `enable`=0: captured and applied at the next start.
  - `enable` falls mid-HIGH: the pulse is truncated, and the next start begins a full period.
- Arithmetic: `cnt` and the period registers are 32-bit unsigned. Compares are full-width. No wrap is possible because `period_cur` ≤ `MAX_PERIOD` < 2^32.

## Timing
- Reset values:
  - `Phase_out`=0, `Phase_start`=0, `active`=0, `load_err`=0.
  - `period_cur`=`DEFAULT_PERIOD`; pending flag=0; state IDLE.
- First rising edge of `Phase_out`: the cycle after `enable` is first sampled high.
- Rising-edge spacing: exactly `period_cur` clocks. High time: exactly `HIGH_CYCLES` clocks.
- `load_err` updates 1 cycle after the offending `period_load`.
- `rst_n` asserted mid-period: all state returns to reset values immediately, without waiting for a boundary.

## Configuration
- `PHASE_GEN_SYNC_EN` defined:
  - Adds input `sync_in` (1 bit, asynchronous), synchronised through 2 flops plus an edge detect.
  - A rising edge of `sync_in` while `enable`=1 forces HIGH with `cnt`=0 and `Phase_start`=1, 3 cycles after the edge. The pending period is applied at that moment.
- `PHASE_GEN_SYNC_EN` undefined: no `sync_in` port; the generator free-runs.

## Structure
- Shared package `phase_pkg`:
  - Constants `PHASE_CNT_W`=32, `PHASE_MAX_PERIOD`=400000000, `PHASE_DEFAULT_PERIOD`=20000000.
  - State typedef `phase_gen_state_t` {IDLE, HIGH, LOW}.
- One sub-module, `phase_period_shadow`: range check, pending register, pending flag, `load_err`, and the boundary-triggered copy into `period_cur`.
- The FSM and counter stay in the top module.

## Test plan
- Reset, then `enable`=1 with `DEFAULT_PERIOD` overridden to 1000:
  - First `Phase_out` rise 1 cycle after `enable`.
  - Rises every 1000 clocks, high for 200 clocks.
  - `Phase_start` fires once per rise.
- Load 5000 mid-LOW of a 1000-cycle period:
  - The current period completes at 1000; the following ones are 5000.
  - A load of 400 landing exactly on a boundary cycle takes effect in that same period.
- Load 399, then 400000001:
  - `load_err`=1 and `period_cur` stays unchanged.
  - A subsequent load of 2000 clears `load_err`.
- Drop `enable` mid-HIGH:
  - `Phase_out` is 0 the next cycle and `active`=0.
  - Re-enable starts a fresh full period.
- Loopback into the phase/period detector with period 10000:
  - The detector's `Phase_cnt_out` settles at 9999 in steady state (it loses one count per measurement).
- `PHASE_GEN_SYNC_EN` build:
  - `sync_in` rising mid-LOW restarts `Phase_out` high exactly 3 cycles later.
  - `rst_n` pulsed low mid-HIGH returns all outputs to reset values.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared constants, state encoding and period range check for the phase generator.
package phase_pkg;

  localparam int unsigned PHASE_CNT_W          = 32;
  localparam int unsigned PHASE_MAX_PERIOD     = 400000000;
  localparam int unsigned PHASE_DEFAULT_PERIOD = 20000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } phase_gen_state_t;

  // True when a requested period lies inside the accepted [lo, hi] window.
  function automatic logic phase_period_ok(
    input logic [PHASE_CNT_W-1:0] p,
    input logic [PHASE_CNT_W-1:0] lo,
    input logic [PHASE_CNT_W-1:0] hi
  );
    return (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/phase_period_shadow.sv
// Validates period loads, holds the pending period and copies it into the
// active period on each period start.
module phase_period_shadow
  import phase_pkg::*;
#(
  parameter int unsigned MIN_PERIOD     = 400,
  parameter int unsigned MAX_PERIOD     = PHASE_MAX_PERIOD,
  parameter int unsigned DEFAULT_PERIOD = PHASE_DEFAULT_PERIOD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  logic [PHASE_CNT_W-1:0] i_period,
  input  logic                   i_apply,
  output logic [PHASE_CNT_W-1:0] o_period_cur,
  output logic                   o_load_err
);

  logic                   w_valid;
  logic [PHASE_CNT_W-1:0] r_pend_val;
  logic                   r_pend;
  logic [PHASE_CNT_W-1:0] r_period_cur;
  logic                   r_load_err;

  assign w_valid = i_load && phase_period_ok(i_period,
                                             PHASE_CNT_W'(MIN_PERIOD),
                                             PHASE_CNT_W'(MAX_PERIOD));

  // A valid load on the start cycle bypasses the pending register so it
  // governs the period that begins right there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val   <= '0;
      r_pend       <= 1'b0;
      r_period_cur <= PHASE_CNT_W'(DEFAULT_PERIOD);
      r_load_err   <= 1'b0;
    end else begin
      if (i_load) r_load_err <= !w_valid;
      if (i_apply) begin
        r_pend <= 1'b0;
        if (w_valid)     r_period_cur <= i_period;
        else if (r_pend) r_period_cur <= r_pend_val;
      end else if (w_valid) begin
        r_pend     <= 1'b1;
        r_pend_val <= i_period;
      end
    end
  end

  assign o_period_cur = r_period_cur;
  assign o_load_err   = r_load_err;

endmodule

// File: rtl/phase_generator.sv
// Programmable periodic pulse source with shadowed period updates.
// Optional external resync input enabled by defining PHASE_GEN_SYNC_EN.
module phase_generator
  import phase_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES    = 200,
  parameter int unsigned MIN_PERIOD     = 400,
  parameter int unsigned MAX_PERIOD     = PHASE_MAX_PERIOD,
  parameter int unsigned DEFAULT_PERIOD = PHASE_DEFAULT_PERIOD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
`ifdef PHASE_GEN_SYNC_EN
  input  logic                   sync_in,
`endif
  input  logic [PHASE_CNT_W-1:0] period_in,
  input  logic                   period_load,
  output logic                   Phase_out,
  output logic                   Phase_start,
  output logic                   active,
  output logic                   load_err,
  output logic [PHASE_CNT_W-1:0] period_cur
);

  phase_gen_state_t       r_state;
  phase_gen_state_t       w_state_nxt;
  logic [PHASE_CNT_W-1:0] r_cnt;
  logic [PHASE_CNT_W-1:0] w_cnt_nxt;
  logic                   w_start;
  logic                   w_sync_rise;
  logic                   r_phase_out;
  logic                   r_phase_start;
  logic                   r_active;

`ifdef PHASE_GEN_SYNC_EN
  logic [2:0] r_sync;

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[1:0], sync_in};
  end

  assign w_sync_rise = r_sync[1] & ~r_sync[2];
`else
  assign w_sync_rise = 1'b0;
`endif

  phase_period_shadow #(
    .MIN_PERIOD     (MIN_PERIOD),
    .MAX_PERIOD     (MAX_PERIOD),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_shadow (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (period_load),
    .i_period     (period_in),
    .i_apply      (w_start),
    .o_period_cur (period_cur),
    .o_load_err   (load_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_phase_out   <= 1'b0;
      r_phase_start <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_phase_out   <= (w_state_nxt == HIGH);
      r_phase_start <= w_start;
      r_active      <= (w_state_nxt != IDLE);
    end
  end

  // Next state; w_start marks every period start (rising edge of the output).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + PHASE_CNT_W'(1);
    w_start     = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (w_sync_rise || (r_state == IDLE)) begin
      w_state_nxt = HIGH;
      w_cnt_nxt   = '0;
      w_start     = 1'b1;
    end else begin
      case (r_state)
        HIGH: begin
          if (r_cnt == PHASE_CNT_W'(HIGH_CYCLES - 1)) w_state_nxt = LOW;
        end
        LOW: begin
          if (r_cnt == period_cur - PHASE_CNT_W'(1)) begin
            w_state_nxt = HIGH;
            w_cnt_nxt   = '0;
            w_start     = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign Phase_out   = r_phase_out;
  assign Phase_start = r_phase_start;
  assign active      = r_active;

endmodule
